// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send,
// bit shifting on device clock edges, ACK check, timeout).
// Optional macro PS2_HOST_TX_RETRY_EN: retry a failed send up to twice with the same byte.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_din_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE, FAIL} state_t;

  state_t        r_state;
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_flt;
  logic          r_clk_flt_d;
  logic [FW-1:0] r_flt_cnt;
  logic [7:0]    r_byte;
  logic [9:0]    r_frame;
  logic [3:0]    r_bit;
  logic [IW-1:0] r_cnt;
  logic [TW-1:0] r_to;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic          r_clk_oe;
  logic          r_dat_oe;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]    r_try;
`endif

  logic w_fall;
  logic w_dat;
  logic w_active;
  logic w_to_hit;
  logic w_fail;

  assign w_fall   = r_clk_flt_d & ~r_clk_flt;
  assign w_dat    = r_dat_sync[1];
  assign w_active = r_state inside {REQ, SHIFT, ACK, RELEASE};
  assign w_to_hit = r_to == TW'(TIMEOUT_CYCLES - 1);
  assign w_fail   = (w_active && w_to_hit) || (r_state == ACK && w_fall && w_dat);

  assign busy       = r_busy;
  assign rx_inhibit = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

  // Synchronize both lines; the clock level only changes after FILTER_LEN agreeing samples.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= 2'b11;
      r_dat_sync  <= 2'b11;
      r_clk_flt   <= 1'b1;
      r_clk_flt_d <= 1'b1;
      r_flt_cnt   <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync  <= {r_dat_sync[0], ps2_din_in};
      r_clk_flt_d <= r_clk_flt;
      if (r_clk_sync[1] == r_clk_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_flt <= r_clk_sync[1];
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  // Transmit FSM; a failure (NACK or timeout) overrides whatever the state did this cycle.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_byte   <= '0;
      r_frame  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_to     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      r_try    <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_active) r_to <= w_to_hit ? r_to : r_to + 1'b1;
      case (r_state)
        IDLE, FAIL: begin
          r_state <= IDLE;
          if (start) begin
            r_byte   <= din;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            r_try    <= '0;
`endif
          end
        end
        INHIBIT: begin
          if (r_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            r_state  <= REQ;
            r_dat_oe <= 1'b1;
            r_to     <= '0;
            r_frame  <= {1'b1, ~^r_byte, r_byte};
            r_bit    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REQ: begin
          r_clk_oe <= 1'b0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          if (w_fall) begin
            r_dat_oe <= ~r_frame[0];
            r_frame  <= {1'b0, r_frame[9:1]};
            r_bit    <= r_bit + 1'b1;
            r_state  <= (r_bit == 4'd9) ? ACK : SHIFT;
          end
        end
        ACK: begin
          if (w_fall && !w_dat) r_state <= RELEASE;
        end
        RELEASE: begin
          if (r_clk_flt && w_dat) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
      if (w_fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
        if (r_try != 2'd2) begin
          r_try    <= r_try + 1'b1;
          r_state  <= INHIBIT;
          r_clk_oe <= 1'b1;
          r_dat_oe <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_state  <= FAIL;
          r_error  <= 1'b1;
          r_busy   <= 1'b0;
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
        end
`else
        r_state  <= FAIL;
        r_error  <= 1'b1;
        r_busy   <= 1'b0;
        r_clk_oe <= 1'b0;
        r_dat_oe <= 1'b0;
`endif
      end
    end
  end
endmodule
